// File: rtl/imm_decode_stage.sv
// Immediate-decode pipeline stage: decodes at push time into a 2-entry skid FIFO.
// Optional macro IMM_DECODE_ZIMM_EN enables the Z (CSR zimm) immediate format.
module imm_decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_target
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [2:0] TYPE_NONE = 3'd0;
    localparam logic [2:0] TYPE_I    = 3'd1;
    localparam logic [2:0] TYPE_S    = 3'd2;
    localparam logic [2:0] TYPE_B    = 3'd3;
    localparam logic [2:0] TYPE_U    = 3'd4;
    localparam logic [2:0] TYPE_J    = 3'd5;
`ifdef IMM_DECODE_ZIMM_EN
    localparam logic [2:0] TYPE_Z    = 3'd6;
`endif

    logic [6:0]      opcode;
    logic [31:0]     imm32;
    logic [2:0]      dec_type;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_target;

    logic [XLEN-1:0] imm_q    [DEPTH];
    logic [2:0]      type_q   [DEPTH];
    logic            ill_q    [DEPTH];
    logic [XLEN-1:0] pc_q     [DEPTH];
    logic [XLEN-1:0] target_q [DEPTH];

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    logic push;
    logic pop;

    assign opcode = in_instr[6:0];

    always_comb begin
        imm32       = '0;
        dec_type    = TYPE_NONE;
        dec_illegal = 1'b0;
        case (opcode)
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: begin
                dec_type = TYPE_I;
                imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    dec_type = TYPE_I;
                    imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            7'b0100011: begin
                dec_type = TYPE_S;
                imm32    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec_type = TYPE_B;
                imm32    = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                            in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_type = TYPE_U;
                imm32    = {in_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_type = TYPE_J;
                imm32    = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                            in_instr[30:21], 1'b0};
            end
            7'b0110011: begin
                dec_type = TYPE_NONE;
            end
            7'b0111011: begin
                dec_illegal = (XLEN != 64);
            end
            7'b1110011: begin
`ifdef IMM_DECODE_ZIMM_EN
                if (in_instr[14:12] != 3'b000) begin
                    dec_type = TYPE_Z;
                    imm32    = {27'b0, in_instr[19:15]};
                end
`endif
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
        // Every format's 32-bit value already carries its sign in bit 31; Z keeps it 0.
        dec_imm       = {XLEN{imm32[31]}};
        dec_imm[31:0] = imm32;
    end

    assign dec_target = in_pc + dec_imm;

    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                imm_q[i]    <= '0;
                type_q[i]   <= '0;
                ill_q[i]    <= 1'b0;
                pc_q[i]     <= '0;
                target_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by overflow.
            if (push) begin
                imm_q[wr_ptr_q]    <= dec_imm;
                type_q[wr_ptr_q]   <= dec_type;
                ill_q[wr_ptr_q]    <= dec_illegal;
                pc_q[wr_ptr_q]     <= in_pc;
                target_q[wr_ptr_q] <= dec_target;
                wr_ptr_q           <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign out_imm      = imm_q[rd_ptr_q];
    assign out_imm_type = type_q[rd_ptr_q];
    assign out_illegal  = ill_q[rd_ptr_q];
    assign out_pc       = pc_q[rd_ptr_q];
    assign out_target   = target_q[rd_ptr_q];

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: XLEN=32 and XLEN=64 instances share one stimulus stream and
// are checked against a queue-based reference model.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        r32, v32, il32;
    logic [31:0] imm32, pc32, tg32;
    logic [2:0]  t32;
    logic        r64, v64, il64;
    logic [63:0] imm64, pc64, tg64;
    logic [2:0]  t64;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .DEPTH(2)) dut32 (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (r32),
        .in_instr     (in_instr),
        .in_pc        (in_pc[31:0]),
        .out_valid    (v32),
        .out_ready    (out_ready),
        .out_imm      (imm32),
        .out_imm_type (t32),
        .out_illegal  (il32),
        .out_pc       (pc32),
        .out_target   (tg32)
    );

    imm_decode_stage #(.XLEN(64), .DEPTH(2)) dut64 (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (r64),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (v64),
        .out_ready    (out_ready),
        .out_imm      (imm64),
        .out_imm_type (t64),
        .out_illegal  (il64),
        .out_pc       (pc64),
        .out_target   (tg64)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } entry_t;

    entry_t q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Decode straight from the opcode table and immediate bit layouts.
    function automatic void ref_decode(input logic [31:0] ins, input int xlen,
                                       output logic [63:0] imm, output logic [2:0] typ,
                                       output logic ill);
        imm = 64'd0;
        typ = 3'd0;
        ill = 1'b0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h0f: begin
                typ = 3'd1; imm = 64'($signed(ins[31:20]));
            end
            7'h1b: begin
                if (xlen == 64) begin typ = 3'd1; imm = 64'($signed(ins[31:20])); end
                else ill = 1'b1;
            end
            7'h23: begin typ = 3'd2; imm = 64'($signed({ins[31:25], ins[11:7]})); end
            7'h63: begin
                typ = 3'd3;
                imm = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            end
            7'h37, 7'h17: begin typ = 3'd4; imm = 64'($signed({ins[31:12], 12'h000})); end
            7'h6f: begin
                typ = 3'd5;
                imm = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            end
            7'h33: typ = 3'd0;
            7'h3b: ill = (xlen != 64);
            7'h73: begin
`ifdef IMM_DECODE_ZIMM_EN
                if (ins[14:12] != 3'b000) begin typ = 3'd6; imm = 64'(ins[19:15]); end
`endif
            end
            default: ill = 1'b1;
        endcase
        if (xlen == 32) imm = imm & 64'hFFFF_FFFF;
    endfunction

    task automatic cmp(input string tag, input int xlen, input logic rdy, input logic vld,
                       input logic [63:0] imm, input logic [2:0] typ, input logic ill,
                       input logic [63:0] pc, input logic [63:0] tgt);
        logic [63:0] e_imm, mask, e_pc;
        logic [2:0]  e_typ;
        logic        e_ill;
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        check({tag, "_in_ready"}, rdy, q.size() != 2);
        check({tag, "_out_valid"}, vld, q.size() != 0);
        if (q.size() != 0) begin
            ref_decode(q[0].instr, xlen, e_imm, e_typ, e_ill);
            e_pc = q[0].pc & mask;
            check({tag, "_imm"}, imm, e_imm);
            check({tag, "_type"}, typ, e_typ);
            check({tag, "_illegal"}, ill, e_ill);
            check({tag, "_pc"}, pc, e_pc);
            check({tag, "_target"}, tgt, (e_pc + e_imm) & mask);
        end
    endtask

    task automatic compare_all();
        cmp("x32", 32, r32, v32, 64'(imm32), t32, il32, 64'(pc32), 64'(tg32));
        cmp("x64", 64, r64, v64, imm64, t64, il64, pc64, tg64);
    endtask

    // One clock: check state, drive inputs, then advance the model at the edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                        input logic ordy, input logic fl);
        bit do_push, do_pop;
        @(negedge clk);
        compare_all();
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        do_push   = v && (q.size() < 2);
        do_pop    = ordy && (q.size() != 0);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{instr: ins, pc: pc});
        end
    endtask

    logic [6:0] ops [13] = '{7'h03, 7'h13, 7'h67, 7'h0f, 7'h1b, 7'h23, 7'h63,
                              7'h37, 7'h17, 7'h6f, 7'h33, 7'h3b, 7'h73};

    initial begin
        logic [31:0] r;
        logic [63:0] rpc;
        logic [6:0]  op;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr  = '0;
        in_pc     = '0;

        #3;
        check("rst_in_ready", r32, 1'b1);
        check("rst_out_valid", v32, 1'b0);
        check("rst_imm", imm64, 64'd0);
        check("rst_type", t64, 3'd0);
        check("rst_illegal", il32, 1'b0);
        check("rst_pc", pc64, 64'd0);
        check("rst_target", tg32, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 32'hFFF0_0093, 64'h100, 1'b1, 1'b0);
        #1;
        check("addi_imm", imm32, 32'hFFFF_FFFF);
        check("addi_type", t32, 3'd1);
        check("addi_target", tg32, 32'h0000_00FF);
        check("addi_illegal", il32, 1'b0);
        step(1'b1, 32'hFE00_0EE3, 64'h200, 1'b1, 1'b0);
        #1;
        check("beq_imm", imm32, 32'hFFFF_FFFC);
        check("beq_type", t32, 3'd3);
        check("beq_target", tg32, 32'h0000_01FC);
        step(1'b1, 32'h0080_006F, 64'h200, 1'b1, 1'b0);
        #1;
        check("jal_imm", imm32, 32'd8);
        check("jal_type", t32, 3'd5);
        check("jal_target", tg32, 32'h0000_0208);
        step(1'b1, 32'h8000_00B7, 64'h0, 1'b1, 1'b0);
        #1;
        check("lui64_imm", imm64, 64'hFFFF_FFFF_8000_0000);
        check("lui64_type", t64, 3'd4);
        step(1'b1, 32'h0000_001B, 64'h0, 1'b1, 1'b0);
        #1;
        check("addiw32_illegal", il32, 1'b1);
        check("addiw32_type", t32, 3'd0);
        check("addiw64_illegal", il64, 1'b0);
        step(1'b1, 32'h3002_D073, 64'h40, 1'b1, 1'b0);
        #1;
`ifdef IMM_DECODE_ZIMM_EN
        check("csrrwi_imm", imm32, 32'd5);
        check("csrrwi_type", t32, 3'd6);
`else
        check("csrrwi_imm", imm32, 32'd0);
        check("csrrwi_type", t32, 3'd0);
`endif

        // Backpressure: third offer is held until the head drains.
        step(1'b1, 32'h0010_0113, 64'h300, 1'b1, 1'b0);
        step(1'b1, 32'h0020_0113, 64'h304, 1'b0, 1'b0);
        step(1'b1, 32'h0030_0113, 64'h308, 1'b0, 1'b0);
        #1;
        check("full_in_ready", r32, 1'b0);
        step(1'b1, 32'h0030_0113, 64'h308, 1'b0, 1'b0);
        step(1'b1, 32'h0030_0113, 64'h308, 1'b1, 1'b0);
        step(1'b1, 32'h0030_0113, 64'h308, 1'b1, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Flush with two held and a live offer.
        step(1'b1, 32'h0040_0113, 64'h400, 1'b0, 1'b0);
        step(1'b1, 32'h0050_0113, 64'h404, 1'b0, 1'b0);
        step(1'b1, 32'h0060_0113, 64'h408, 1'b0, 1'b1);
        #1;
        check("flush_out_valid", v32, 1'b0);
        check("flush_in_ready", r64, 1'b1);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        for (int c = 0; c < 600; c++) begin
            r   = $urandom();
            rpc = {$urandom(), $urandom()};
            op  = ($urandom_range(0, 4) == 0) ? r[6:0] : ops[$urandom_range(0, 12)];
            step($urandom_range(0, 9) < 7, {r[31:7], op}, rpc,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
            if (c == 300) begin
                @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                check("midrst_out_valid32", v32, 1'b0);
                check("midrst_out_valid64", v64, 1'b0);
                check("midrst_in_ready", r32, 1'b1);
                q.delete();
                @(negedge clk);
                in_valid = 1'b0;
                flush    = 1'b0;
                rst_n    = 1'b1;
            end
        end
        @(negedge clk);
        compare_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
